spi_reg_ctrl: RTL and testbench

Byte-level command controller between the SPI slave byte interface and an 8-bit register bus. It decodes the first MOSI byte of each chip-select frame as a read/write command with a 7-bit start address. It streams the following bytes to or from consecutive registers with auto-increment, and keeps the MISO byte prefetched so it is valid when the SPI core requests it. It sits between the SPI slave and the miner's configuration/status register file.

---
 rtl/spi_reg_ctrl_if.sv | 27 ++
 rtl/spi_reg_ctrl.sv | 101 ++++++++++
 tb/tb_spi_reg_ctrl.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/spi_reg_ctrl_if.sv
// spi_reg_ctrl_if: SPI byte-side and register-bus signals of spi_reg_ctrl.
// master is the controller's view, slave is the SPI core / register file side.
interface spi_reg_ctrl_if;
    logic       start_of_transfer;
    logic       end_of_transfer;
    logic [7:0] mosi_data_out;
    logic       mosi_data_ready;
    logic       miso_data_request;
    logic [7:0] miso_data_in;
    logic [6:0] reg_addr;
    logic [7:0] reg_wdata;
    logic       reg_wr;
    logic       reg_rd;
    logic [7:0] reg_rdata;
    logic       busy;
    logic       addr_err;
    modport master (
        input  start_of_transfer, end_of_transfer, mosi_data_out, mosi_data_ready,
               miso_data_request, reg_rdata,
        output miso_data_in, reg_addr, reg_wdata, reg_wr, reg_rd, busy, addr_err
    );
    modport slave (
        output start_of_transfer, end_of_transfer, mosi_data_out, mosi_data_ready,
               miso_data_request, reg_rdata,
        input  miso_data_in, reg_addr, reg_wdata, reg_wr, reg_rd, busy, addr_err
    );
endinterface

// File: rtl/spi_reg_ctrl.sv
// spi_reg_ctrl: decodes SPI command frames into auto-incrementing register
// writes/reads, keeping the next MISO byte prefetched.
module spi_reg_ctrl #(
    parameter int         NUM_REGS    = 128,
    parameter logic [7:0] STATUS_BYTE = 8'hA5
) (
    input  logic                  iCLK,
    input  logic                  RST,
    spi_reg_ctrl_if.master        bus
);
    typedef enum logic [2:0] {IDLE, CMD, WR, RD_ISSUE, RD_CAP, RD_HOLD} state_t;
    state_t     r_state, w_state;
    logic [6:0] r_addr, w_addr, r_reg_addr, w_reg_addr;
    logic [7:0] r_miso, w_miso, r_wdata, w_wdata;
    logic       r_wr, w_wr, r_rd, w_rd, r_err, w_err;

    function automatic logic in_rng(input logic [6:0] a);
        return 32'(a) < NUM_REGS;
    endfunction

    always_comb begin
        w_state    = r_state;
        w_addr     = r_addr;
        w_miso     = r_miso;
        w_reg_addr = r_reg_addr;
        w_wdata    = r_wdata;
        w_wr       = 1'b0;
        w_rd       = 1'b0;
        w_err      = 1'b0;
        case (r_state)
            IDLE: ;
            CMD: if (bus.mosi_data_ready) begin
                w_addr  = bus.mosi_data_out[6:0];
                w_state = bus.mosi_data_out[7] ? RD_ISSUE : WR;
            end
            WR: if (bus.mosi_data_ready) begin
                w_reg_addr = r_addr;
                w_wdata    = bus.mosi_data_out;
                w_wr       = in_rng(r_addr);
                w_err      = !in_rng(r_addr);
                w_addr     = r_addr + 7'd1;
            end
            RD_ISSUE: w_state = RD_CAP;
            RD_CAP: begin
                w_miso  = in_rng(r_addr) ? bus.reg_rdata : 8'h00;
                w_addr  = r_addr + 7'd1;
                w_state = RD_HOLD;
            end
            RD_HOLD: if (bus.miso_data_request) w_state = RD_ISSUE;
            default: w_state = IDLE;
        endcase
        // A write completing with the frame end still lands; a prefetch does not.
        if (bus.end_of_transfer) begin
            w_state = IDLE;
            w_miso  = r_miso;
        end
        if (bus.start_of_transfer) begin
            w_state = CMD;
            w_addr  = 7'd0;
            w_miso  = STATUS_BYTE;
            w_wr    = 1'b0;
            w_err   = 1'b0;
        end
        // Read strobe is registered so it is high for the whole RD_ISSUE cycle.
        if (w_state == RD_ISSUE) begin
            w_reg_addr = w_addr;
            w_rd       = in_rng(w_addr);
            w_err      = !in_rng(w_addr);
        end
    end

    always_ff @(posedge iCLK) begin
        if (RST) begin
            r_state    <= IDLE;
            r_addr     <= 7'd0;
            r_miso     <= 8'h00;
            r_reg_addr <= 7'd0;
            r_wdata    <= 8'h00;
            r_wr       <= 1'b0;
            r_rd       <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_state    <= w_state;
            r_addr     <= w_addr;
            r_miso     <= w_miso;
            r_reg_addr <= w_reg_addr;
            r_wdata    <= w_wdata;
            r_wr       <= w_wr;
            r_rd       <= w_rd;
            r_err      <= w_err;
        end
    end

    assign bus.miso_data_in = r_miso;
    assign bus.reg_addr     = r_reg_addr;
    assign bus.reg_wdata    = r_wdata;
    assign bus.reg_wr       = r_wr;
    assign bus.reg_rd       = r_rd;
    assign bus.addr_err     = r_err;
    assign bus.busy         = r_state != IDLE;
endmodule

// File: tb/tb_spi_reg_ctrl.sv
// tb_spi_reg_ctrl: frame-level checks of spi_reg_ctrl with 128 and 16 registers
// against a per-frame model of expected strobes, MISO bytes and errors.
module tb_spi_reg_ctrl;
    logic iCLK = 1'b0;
    logic RST  = 1'b1;
    always #5 iCLK = ~iCLK;

    logic       sot = 0, eot = 0, rdy = 0, req = 0;
    logic [7:0] mosi = 0, rd0, rd1;
    logic [7:0] bus_mem [128];
    logic [7:0] ref_mem [128];

    spi_reg_ctrl_if if0();
    spi_reg_ctrl_if if1();
    assign if0.start_of_transfer = sot;
    assign if0.end_of_transfer   = eot;
    assign if0.mosi_data_out     = mosi;
    assign if0.mosi_data_ready   = rdy;
    assign if0.miso_data_request = req;
    assign if0.reg_rdata         = rd0;
    assign if1.start_of_transfer = sot;
    assign if1.end_of_transfer   = eot;
    assign if1.mosi_data_out     = mosi;
    assign if1.mosi_data_ready   = rdy;
    assign if1.miso_data_request = req;
    assign if1.reg_rdata         = rd1;

    spi_reg_ctrl #(.NUM_REGS(128)) u0 (.iCLK(iCLK), .RST(RST), .bus(if0.master));
    spi_reg_ctrl #(.NUM_REGS(16))  u1 (.iCLK(iCLK), .RST(RST), .bus(if1.master));

    function automatic logic [7:0] init_val(input int i);
        return (i == 1) ? 8'h3C : (i == 2) ? 8'hC3 : 8'(i * 29 + 7);
    endfunction

    // Register file slave; only the 128-register controller writes it.
    always @(posedge iCLK) begin
        if (RST) begin
            for (int i = 0; i < 128; i++) bus_mem[i] <= init_val(i);
        end else if (if0.reg_wr) bus_mem[if0.reg_addr] <= if0.reg_wdata;
        rd0 <= if0.reg_rd ? bus_mem[if0.reg_addr] : 8'hEE;
        rd1 <= if1.reg_rd ? bus_mem[if1.reg_addr] : 8'hEE;
    end

    logic [14:0] wq0[$], wq1[$];
    logic [6:0]  rq0[$], rq1[$];
    logic [7:0]  mq0[$], mq1[$];
    int ne0 = 0, ne1 = 0, lat_bad = 0;
    logic prev_rdy = 0;
    always @(negedge iCLK) begin
        if (if0.reg_wr) wq0.push_back({if0.reg_addr, if0.reg_wdata});
        if (if1.reg_wr) wq1.push_back({if1.reg_addr, if1.reg_wdata});
        if (if0.reg_rd) rq0.push_back(if0.reg_addr);
        if (if1.reg_rd) rq1.push_back(if1.reg_addr);
        if (if0.addr_err) ne0++;
        if (if1.addr_err) ne1++;
        if (req) begin
            mq0.push_back(if0.miso_data_in);
            mq1.push_back(if1.miso_data_in);
        end
        if ((if0.reg_wr || if1.reg_wr) && !prev_rdy) lat_bad++;
        prev_rdy = rdy;
    end

    int n_cmp = 0, n_bad = 0;
    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge iCLK);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic send_byte(input logic [7:0] b, input logic r);
        idle(6);
        mosi = b; rdy = 1; req = r;
        tick();
        rdy = 0; req = 0;
    endtask

    task automatic clear_caps();
        wq0.delete(); wq1.delete(); rq0.delete(); rq1.delete();
        mq0.delete(); mq1.delete(); ne0 = 0; ne1 = 0;
    endtask

    function automatic logic [7:0] dbyte(input logic [7:0] d0, input int j);
        return 8'(d0 + 8'(j) * 8'h11);
    endfunction

    task automatic frame(input logic [7:0] cmd, input int nb, input logic [7:0] d0);
        clear_caps();
        sot = 1; tick(); sot = 0;
        send_byte(cmd, nb > 0);
        for (int j = 0; j < nb; j++)
            send_byte(cmd[7] ? 8'($urandom) : dbyte(d0, j), j < nb - 1);
        idle(6);
        chk("busy_mid", int'(if0.busy), 1);
        eot = 1; tick(); eot = 0;
        chk("busy_end", int'(if0.busy), 0);
        idle(4);
    endtask

    // Expected behaviour of one frame for a controller with n registers.
    task automatic check_dut(input int k, input int n, input logic [7:0] cmd, input int nb,
                             input logic [7:0] d0);
        logic [14:0] ew[$], cw[$];
        logic [6:0]  er[$], cr[$];
        logic [7:0]  em[$], cm[$];
        logic [6:0]  a;
        int eerr = 0, cerr;
        string p = (k == 0) ? "n128" : "n16";
        if (k == 0) begin cw = wq0; cr = rq0; cm = mq0; cerr = ne0; end
        else begin cw = wq1; cr = rq1; cm = mq1; cerr = ne1; end
        for (int j = 0; j < nb; j++) begin
            a = 7'(cmd[6:0] + j - 1);
            em.push_back((cmd[7] && j > 0) ? ((int'(a) < n) ? ref_mem[a] : 8'h00) : 8'hA5);
        end
        if (!cmd[7]) begin
            for (int j = 0; j < nb; j++) begin
                a = 7'(cmd[6:0] + j);
                if (int'(a) < n) ew.push_back({a, dbyte(d0, j)}); else eerr++;
            end
        end else begin
            for (int j = 0; j < ((nb == 0) ? 1 : nb); j++) begin
                a = 7'(cmd[6:0] + j);
                if (int'(a) < n) er.push_back(a); else eerr++;
            end
        end
        chk({p, "_nwr"}, cw.size(), ew.size());
        chk({p, "_nrd"}, cr.size(), er.size());
        chk({p, "_nmiso"}, cm.size(), em.size());
        chk({p, "_nerr"}, cerr, eerr);
        for (int j = 0; j < ew.size() && j < cw.size(); j++) chk({p, "_wr"}, cw[j], ew[j]);
        for (int j = 0; j < er.size() && j < cr.size(); j++) chk({p, "_rd"}, cr[j], er[j]);
        for (int j = 0; j < em.size() && j < cm.size(); j++) chk({p, "_miso"}, cm[j], em[j]);
    endtask

    task automatic run_checked(input logic [7:0] cmd, input int nb, input logic [7:0] d0);
        frame(cmd, nb, d0);
        check_dut(0, 128, cmd, nb, d0);
        check_dut(1, 16, cmd, nb, d0);
        if (!cmd[7]) for (int j = 0; j < nb; j++) ref_mem[7'(cmd[6:0] + j)] = dbyte(d0, j);
    endtask

    task automatic init_ref();
        for (int i = 0; i < 128; i++) ref_mem[i] = init_val(i);
    endtask

    typedef struct {
        logic [7:0] cmd;
        int         nb;
        logic [7:0] d0;
        int         exp_wr0;
        int         exp_rd0;
        int         exp_err16;
    } vec_t;

    initial begin
        vec_t vecs[7];
        vecs[0] = '{8'h05, 2, 8'h11, 2, 0, 0};
        vecs[1] = '{8'h81, 3, 8'h00, 0, 3, 0};
        vecs[2] = '{8'hFF, 4, 8'h00, 0, 4, 1};
        vecs[3] = '{8'h10, 1, 8'h55, 1, 0, 1};
        vecs[4] = '{8'h90, 2, 8'h00, 0, 2, 2};
        vecs[5] = '{8'h05, 0, 8'h00, 0, 0, 0};
        vecs[6] = '{8'h8F, 1, 8'h00, 0, 1, 0};
        init_ref();
        idle(3);
        RST = 0;
        chk("rst_miso", int'(if0.miso_data_in), 0);
        chk("rst_addr", int'(if0.reg_addr), 0);
        chk("rst_wdata", int'(if0.reg_wdata), 0);
        chk("rst_wr", int'(if0.reg_wr), 0);
        chk("rst_rd", int'(if0.reg_rd), 0);
        chk("rst_busy", int'(if0.busy), 0);
        chk("rst_err", int'(if0.addr_err), 0);

        foreach (vecs[i]) begin
            run_checked(vecs[i].cmd, vecs[i].nb, vecs[i].d0);
            chk("vec_wr0", wq0.size(), vecs[i].exp_wr0);
            chk("vec_rd0", rq0.size(), vecs[i].exp_rd0);
            chk("vec_err16", ne1, vecs[i].exp_err16);
        end

        // Last data byte and frame end in the same cycle.
        clear_caps();
        sot = 1; tick(); sot = 0;
        send_byte(8'h07, 1);
        idle(6);
        mosi = 8'h99; rdy = 1; eot = 1;
        tick();
        rdy = 0; eot = 0;
        chk("wr_eot_strobe", int'(if0.reg_wr), 1);
        chk("wr_eot_addr", int'(if0.reg_addr), 7);
        chk("wr_eot_data", int'(if0.reg_wdata), 8'h99);
        chk("wr_eot_busy", int'(if0.busy), 0);
        ref_mem[7] = 8'h99;
        idle(4);

        // Reset while a prefetched byte is held.
        sot = 1; tick(); sot = 0;
        send_byte(8'h81, 1);
        idle(6);
        chk("hold_busy", int'(if0.busy), 1);
        chk("hold_miso", int'(if0.miso_data_in), int'(ref_mem[1]));
        RST = 1; tick(); RST = 0;
        chk("rst_hold_busy", int'(if0.busy), 0);
        chk("rst_hold_miso", int'(if0.miso_data_in), 0);
        chk("rst_hold_rd", int'(if0.reg_rd), 0);
        chk("rst_hold_busy16", int'(if1.busy), 0);
        init_ref();
        run_checked(8'h81, 3, 8'h00);

        // New frame start without a preceding end.
        sot = 1; tick(); sot = 0;
        send_byte(8'h03, 1);
        idle(3);
        run_checked(8'h82, 2, 8'h00);

        for (int i = 0; i < 25; i++)
            run_checked(8'($urandom), int'($urandom_range(0, 5)), 8'($urandom));

        chk("wr_latency", lat_bad, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
